// File: rtl/uart_rx_16550_if.sv
// uart_rx_16550_if
// Read-side bundle of the 16550-style receiver. It carries the FIFO head
// (data + error flags), the occupancy/status signals and the host-side
// control pulses.
//   slave  : the receiver; drives head/status, takes rd_en/fifo_clr/ovr_clr
//   master : the host; drives rd_en/fifo_clr/ovr_clr, takes head/status
// Ports: rd_en, fifo_clr, ovr_clr (host -> rx); rd_data[7:0], rd_pe, rd_fe,
//        rd_bi, empty, count, overrun (rx -> host)
interface uart_rx_16550_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic          fifo_clr;
  logic          ovr_clr;
  logic [7:0]    rd_data;
  logic          rd_pe;
  logic          rd_fe;
  logic          rd_bi;
  logic          empty;
  logic [CW-1:0] count;
  logic          overrun;

  modport slave (
    input  rd_en, fifo_clr, ovr_clr,
    output rd_data, rd_pe, rd_fe, rd_bi, empty, count, overrun
  );

  modport master (
    output rd_en, fifo_clr, ovr_clr,
    input  rd_data, rd_pe, rd_fe, rd_bi, empty, count, overrun
  );
endinterface

// File: rtl/uart_rx_16550.sv
// uart_rx_16550
// 16550-style serial receiver: input synchronizer, 16x-oversampled frame
// FSM (start/data/parity/stop), error/break detection and a
// first-word-fall-through receive FIFO with sticky overrun.
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   baud_tick          one-clk pulse at 16x the baud rate
//   rx_i               asynchronous serial line, idle high
//   lcr_wls/pen/eps/sp line control: word length, parity enable/even/stick
//   rd_if (slave)      FIFO head, status and host control pulses
module uart_rx_16550 #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  rx_i,
  input  logic [1:0]            lcr_wls,
  input  logic                  lcr_pen,
  input  logic                  lcr_eps,
  input  logic                  lcr_sp,
  uart_rx_16550_if.slave        rd_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

  state_e           state_q, state_d;
  logic [3:0]       tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             pe_q, pe_d;
  logic [1:0]       wls_q, wls_d;
  logic             pen_q, pen_d, eps_q, eps_d, sp_q, sp_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             rxs;
  logic             busy;
  logic             push;
  logic [10:0]      push_entry;
  logic             exp_par;
  logic [2:0]       last_bit;

  logic [10:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ovr_q, ovr_d;
  logic             empty, full, pop, wr_en, ovr_set;
  logic [10:0]      head;

  // Synchronizer: the line idles high, so every stage resets to 1 to avoid
  // a phantom start bit out of reset.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
      wls_q   <= '0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      sp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      pe_q    <= pe_d;
      wls_q   <= wls_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
      sp_q    <= sp_d;
    end
  end

  // Expected parity uses the line control latched at the start of the frame.
  assign exp_par  = sp_q ? ~eps_q : (^data_q ^ ~eps_q);
  assign last_bit = 3'd4 + {1'b0, wls_q};

  // Next-state: START counts 8 ticks to the centre of the start bit, so each
  // later 16-tick period (tick_q wrapping at 15) lands on a bit centre.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    pe_d    = pe_q;
    wls_d   = wls_q;
    pen_d   = pen_q;
    eps_d   = eps_q;
    sp_d    = sp_q;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd7) begin
            if (!rxs) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
              data_d  = '0;
              par_d   = 1'b0;
              pe_d    = 1'b0;
              wls_d   = lcr_wls;
              pen_d   = lcr_pen;
              eps_d   = lcr_eps;
              sp_d    = lcr_sp;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            data_d[bit_q] = rxs;
            if (bit_q == last_bit) state_d = pen_q ? PARITY : STOP;
            else                   bit_d   = bit_q + 3'd1;
          end
        end
        PARITY: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            par_d   = rxs;
            pe_d    = rxs ^ exp_par;
            state_d = STOP;
          end
        end
        STOP: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) state_d = rxs ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: the entry is pushed on the stop-bit sample. A break is an
  // all-zero frame including parity (when enabled) and the stop bit.
  always_comb begin
    busy       = (state_q != IDLE);
    push       = (state_q == STOP) && baud_tick && (tick_q == 4'd15);
    push_entry = '0;
    if ((data_q == 8'h00) && (!pen_q || !par_q) && !rxs)
      push_entry = {1'b1, 1'b1, pe_q, 8'h00};
    else
      push_entry = {1'b0, ~rxs, pe_q, data_q};
  end

  // FIFO control: clear beats push; a push into a full FIFO only succeeds
  // when a pop frees a slot in the same clock.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rd_if.rd_en && !empty;
  assign wr_en   = push && !rd_if.fifo_clr && (!full || pop);
  assign ovr_set = push && !rd_if.fifo_clr && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovr_d = ovr_q;
    if (ovr_set)               ovr_d = 1'b1;
    else if (rd_if.ovr_clr)    ovr_d = 1'b0;
  end

  // Storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      if (rd_if.fifo_clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_d;
      end
    end
  end

  assign head            = empty ? 11'h000 : mem_q[rd_ptr_q];
  assign rd_if.rd_data   = head[7:0];
  assign rd_if.rd_pe     = head[8];
  assign rd_if.rd_fe     = head[9];
  assign rd_if.rd_bi     = head[10];
  assign rd_if.empty     = empty;
  assign rd_if.count     = count_q;
  assign rd_if.overrun   = ovr_q;

endmodule
